// File: rtl/mmc_block_rx_pkg.sv
// Shared definitions for the MMC/SD block-read receive engine.
// State encoding, protocol byte constants, error codes and CRC polynomial.
package mmc_block_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TOKEN,
    ST_DATA,
    ST_CRC_H,
    ST_CRC_L
  } rx_state_t;

  localparam logic [7:0]  C_START_TOKEN     = 8'hFE;
  localparam logic [7:0]  C_IDLE_BYTE       = 8'hFF;

  localparam logic [1:0]  ERR_TOKEN_TIMEOUT = 2'd0;
  localparam logic [1:0]  ERR_DATA_TOKEN    = 2'd1;
  localparam logic [1:0]  ERR_CRC           = 2'd2;

  localparam logic [15:0] C_CRC16_POLY      = 16'h1021;

  // Big-endian lane: byte 0 of a word lands in bits [31:24]; 0 = write, 1 = protect.
  function automatic logic [3:0] lane_mask(input logic [1:0] idx);
    return ~(4'b1000 >> idx);
  endfunction

endpackage

// File: rtl/mmc_crc16_byte.sv
// Combinational one-byte step of CRC-16-CCITT, MSB first.
module mmc_crc16_byte
  import mmc_block_rx_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data_byte,
  output logic [15:0] crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int unsigned i = 0; i < 8; i++) begin
      if (crc_out[15] ^ data_byte[3'(7 - i)])
        crc_out = {crc_out[14:0], 1'b0} ^ C_CRC16_POLY;
      else
        crc_out = {crc_out[14:0], 1'b0};
    end
  end

endmodule

// File: rtl/mmc_block_rx.sv
// Single-block read receiver: start-token poll, 512 data bytes into the sector buffer, CRC bytes.
// Optional CRC-16 check of the data bytes is built when MMC_BLOCK_RX_CRC16_EN is defined.
module mmc_block_rx
  import mmc_block_rx_pkg::*;
#(
  parameter int unsigned P_TOKEN_TIMEOUT = 1024
) (
  input  logic        iCLOCK,
  input  logic        iRESET_SYNC,
  input  logic        iSTART,
  output logic        oBUSY,
  output logic        oDONE,
  output logic        oERROR,
  output logic [1:0]  oERR_CODE,
  output logic        oSPI_REQ,
  input  logic        iSPI_BUSY,
  input  logic        iSPI_VALID,
  input  logic [7:0]  iSPI_DATA,
  output logic        oWR_REQ,
  output logic [3:0]  oWR_MASK,
  output logic [6:0]  oWR_ADDR,
  output logic [31:0] oWR_DATA
);

  rx_state_t   state, state_n;
  logic        phase_wait, phase_wait_n;
  logic [8:0]  byte_cnt;
  logic [15:0] poll_cnt;
  logic        rx_byte;
  logic        poll_last;
  logic        crc_ok;

  assign rx_byte   = (state != ST_IDLE) && phase_wait && iSPI_VALID;
  assign poll_last = ({1'b0, poll_cnt} + 17'd1) == 17'(P_TOKEN_TIMEOUT);

`ifdef MMC_BLOCK_RX_CRC16_EN
  logic [15:0] crc, crc_next;
  logic [7:0]  crc_h;

  mmc_crc16_byte u_crc (
    .crc_in    (crc),
    .data_byte (iSPI_DATA),
    .crc_out   (crc_next)
  );

  assign crc_ok = ({crc_h, iSPI_DATA} == crc);

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      crc   <= '0;
      crc_h <= '0;
    end else if (state == ST_IDLE && iSTART) begin
      crc   <= '0;
    end else if (rx_byte && state == ST_DATA) begin
      crc   <= crc_next;
    end else if (rx_byte && state == ST_CRC_H) begin
      crc_h <= iSPI_DATA;
    end
  end
`else
  assign crc_ok = 1'b1;
`endif

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      state      <= ST_IDLE;
      phase_wait <= 1'b0;
    end else begin
      state      <= state_n;
      phase_wait <= phase_wait_n;
    end
  end

  always_comb begin
    state_n      = state;
    phase_wait_n = phase_wait;
    if (state == ST_IDLE) begin
      if (iSTART) begin
        state_n      = ST_TOKEN;
        phase_wait_n = 1'b0;
      end
    end else if (!phase_wait) begin
      if (!iSPI_BUSY) phase_wait_n = 1'b1;
    end else if (iSPI_VALID) begin
      phase_wait_n = 1'b0;
      case (state)
        ST_TOKEN: begin
          if (iSPI_DATA == C_IDLE_BYTE) begin
            if (poll_last) state_n = ST_IDLE;
          end else if (iSPI_DATA == C_START_TOKEN) begin
            state_n = ST_DATA;
          end else begin
            state_n = ST_IDLE;
          end
        end
        ST_DATA:  if (byte_cnt == 9'd511) state_n = ST_CRC_H;
        ST_CRC_H: state_n = ST_CRC_L;
        ST_CRC_L: state_n = ST_IDLE;
        default:  state_n = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    oBUSY    = (state != ST_IDLE);
    oSPI_REQ = (state != ST_IDLE) && !phase_wait;
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      byte_cnt  <= '0;
      poll_cnt  <= '0;
      oDONE     <= 1'b0;
      oERROR    <= 1'b0;
      oERR_CODE <= ERR_TOKEN_TIMEOUT;
      oWR_REQ   <= 1'b0;
      oWR_MASK  <= '1;
      oWR_ADDR  <= '0;
      oWR_DATA  <= '0;
    end else begin
      oDONE   <= 1'b0;
      oERROR  <= 1'b0;
      oWR_REQ <= 1'b0;
      if (state == ST_IDLE && iSTART) begin
        byte_cnt  <= '0;
        poll_cnt  <= '0;
        oERR_CODE <= ERR_TOKEN_TIMEOUT;
      end else if (rx_byte) begin
        case (state)
          ST_TOKEN: begin
            if (iSPI_DATA == C_IDLE_BYTE) begin
              poll_cnt <= poll_cnt + 16'd1;
              if (poll_last) begin
                oERROR    <= 1'b1;
                oERR_CODE <= ERR_TOKEN_TIMEOUT;
              end
            end else if (iSPI_DATA != C_START_TOKEN) begin
              oERROR    <= 1'b1;
              oERR_CODE <= ERR_DATA_TOKEN;
            end
          end
          ST_DATA: begin
            oWR_REQ  <= 1'b1;
            oWR_ADDR <= byte_cnt[8:2];
            oWR_MASK <= lane_mask(byte_cnt[1:0]);
            oWR_DATA <= {4{iSPI_DATA}};
            byte_cnt <= byte_cnt + 9'd1;
          end
          ST_CRC_L: begin
            if (crc_ok) begin
              oDONE <= 1'b1;
            end else begin
              oERROR    <= 1'b1;
              oERR_CODE <= ERR_CRC;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
